wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single internal register bus between several masters.
- Example masters: the serial command builder and a future autonomous init/housekeeping sequencer.
- Sits between the masters and the bus dispatcher; grants a whole bus cycle (cyc tenure) to one master at a time.
- A per-transfer watchdog completes hung transfers so a missing slave ack cannot lock the bus.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..8).
- ADDR_WIDTH, 16, Wishbone address width.
- TIMEOUT, 1023, cycles stb may wait for ack before the arbiter forces completion (>=2).

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- m_wb_cyc_i  in  NUM_MASTERS  per-master cyc (request).
- m_wb_stb_i  in  NUM_MASTERS  per-master stb.
- m_wb_we_i  in  NUM_MASTERS  per-master write enable.
- m_wb_adr_i  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- m_wb_dat_i  in  NUM_MASTERS*8  flattened write data; master k at [k*8 +: 8].
- m_wb_dat_o  out  8  read data, broadcast to all masters.
- m_wb_ack_o  out  NUM_MASTERS  per-master ack.
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1 each  to dispatcher.
- s_wb_adr_o  out  ADDR_WIDTH  to dispatcher.
- s_wb_dat_o  out  8  to dispatcher.
- s_wb_dat_i  in  8  read data from dispatcher.
- s_wb_ack_i  in  1  ack from dispatcher.
- grant  out  NUM_MASTERS  one-hot registered grant, all-zero when idle.
- timeout_count  out  8  saturating count of forced completions.

Behaviour:
- Reset values: grant=0, state=IDLE, last=NUM_MASTERS-1 (master 0 has first priority), timeout_count=0, timer=0.
- Reset mid-transfer abandons the tenure immediately; no ack is issued for it.
- States: IDLE, BUSY, TOACK.
- IDLE:
  - All s_wb_* outputs are 0 and m_wb_ack_o=0.
  - If any m_wb_cyc_i is set, pick the first requester scanning from last+1 upward modulo NUM_MASTERS, load grant, go to BUSY.
  - Arbitration latency is 1 cycle: the slave sees the request the cycle after the grant is registered.
- BUSY (g = granted index):
  - s_wb_cyc_o = m_wb_cyc_i[g]; s_wb_stb_o = m_wb_stb_i[g]; s_wb_we_o, s_wb_adr_o, s_wb_dat_o come from master g (combinational mux on the registered grant).
  - m_wb_ack_o[g] = s_wb_ack_i; all other acks are 0.
  - m_wb_dat_o = s_wb_dat_i.
- Release:
  - When m_wb_cyc_i[g]=0 in BUSY: last<=g, grant<=0, go to IDLE.
  - At least one IDLE cycle always separates tenures.
  - A master may run multiple stb transfers within one cyc tenure; other masters wait.
- Watchdog:
  - timer increments each BUSY cycle with stb=1 and ack=0.
  - timer clears on ack, on stb=0, and on entering BUSY.
  - When timer==TIMEOUT-1 and ack=0, go to TOACK.
  - If ack arrives on that same cycle, the ack wins and no timeout occurs.
- TOACK (1 cycle):
  - s_wb_cyc_o=0 and s_wb_stb_o=0.
  - m_wb_ack_o[g]=1 and m_wb_dat_o=8'hFF.
  - timeout_count increments, saturating at 255.
  - Next state is BUSY if m_wb_cyc_i[g]=1, else IDLE (with the release actions).
- Masters that are not granted never receive ack and must hold their request.
- Requests arriving while BUSY wait; grant never changes mid-tenure.
- NUM_MASTERS=1 degenerates to pass-through with the 1-cycle grant latency and the watchdog still active.

Decomposition:
- Shared package:
  - State encoding (ARB_IDLE, ARB_BUSY, ARB_TOACK).
  - WB_DATA_WIDTH=8.
  - TIMEOUT_READ_VALUE=8'hFF.
- One sub-module, rr_pick: combinational round-robin priority encoder with inputs req vector and last index, outputs one-hot pick and valid.

Test Plan:
- Single master read: m0 cyc/stb with adr=16'h0102; slave acks after 3 cycles with dat 8'h5A → grant=01 one cycle after request, m_wb_ack_o[0] pulses once, m_wb_dat_o=8'h5A.
- Simultaneous requests from m0 and m1 out of reset → m0 served first; after m0 drops cyc, one IDLE cycle, then grant=10.
- Fairness: both masters continuously re-request 6 transfers each → grants alternate 01,10,01,… with no master served twice in a row.
- Timeout: TIMEOUT=8; slave never acks m1 write → after 8 stb cycles, one TOACK cycle with s_wb_cyc_o=0, m_wb_ack_o[1]=1, m_wb_dat_o=8'hFF, timeout_count=1.
- Timeout edge: slave acks on exactly cycle TIMEOUT-1 → normal ack with slave data, timeout_count unchanged.
- Reset mid-transfer: assert rst while BUSY with stb pending → next cycle grant=0, s_wb_cyc_o=0, no ack emitted; after release m0 is granted first.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// ============================================================
// wb_arbiter_pkg : shared types and constants for wb_arbiter
// Rev 1.0
// ============================================================
`default_nettype none

package wb_arbiter_pkg;

  localparam int WB_DATA_WIDTH = 8;
  localparam logic [WB_DATA_WIDTH-1:0] TIMEOUT_READ_VALUE = 8'hFF;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_TOACK = 2'd2
  } arb_state_e;

  // A one-master build still needs a 1-bit index to stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_rr_pick.sv
// ============================================================
// rr_pick : combinational round-robin priority encoder
// Rev 1.0
// ============================================================
`default_nettype none

module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     pick,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  // Scan from last+1 upward so the most recently served master is tried last.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IDX_W'((int'(last) + i) % N);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================
// wb_arbiter : round-robin Wishbone arbiter with ack watchdog
// Rev 1.0
// ============================================================
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int TIMEOUT     = 1023
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_MASTERS-1:0]               m_wb_cyc_i,
  input  logic [NUM_MASTERS-1:0]               m_wb_stb_i,
  input  logic [NUM_MASTERS-1:0]               m_wb_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_wb_adr_i,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_wb_dat_i,
  output logic [WB_DATA_WIDTH-1:0]             m_wb_dat_o,
  output logic [NUM_MASTERS-1:0]               m_wb_ack_o,
  output logic                                 s_wb_cyc_o,
  output logic                                 s_wb_stb_o,
  output logic                                 s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]                s_wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0]             s_wb_dat_o,
  input  logic [WB_DATA_WIDTH-1:0]             s_wb_dat_i,
  input  logic                                 s_wb_ack_i,
  output logic [NUM_MASTERS-1:0]               grant,
  output logic [7:0]                           timeout_count
);

  localparam int IDX_W = idx_width(NUM_MASTERS);
  localparam int TMR_W = $clog2(TIMEOUT);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [7:0]             tcount_q, tcount_d;

  logic [NUM_MASTERS-1:0]   pick;
  logic                     pick_valid;
  logic                     cyc_g, stb_g, we_g;
  logic [ADDR_WIDTH-1:0]    adr_g;
  logic [WB_DATA_WIDTH-1:0] dat_g;
  logic [IDX_W-1:0]         g_idx;

  rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (m_wb_cyc_i),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Granted-master mux, driven purely by the registered one-hot grant.
  always_comb begin
    cyc_g = |(m_wb_cyc_i & grant_q);
    stb_g = |(m_wb_stb_i & grant_q);
    we_g  = |(m_wb_we_i & grant_q);
    adr_g = '0;
    dat_g = '0;
    g_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        adr_g = m_wb_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        dat_g = m_wb_dat_i[k*WB_DATA_WIDTH +: WB_DATA_WIDTH];
        g_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    timer_d  = timer_q;
    tcount_d = tcount_q;
    case (state_q)
      ARB_IDLE: begin
        timer_d = '0;
        if (pick_valid) begin
          grant_d = pick;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!cyc_g) begin
          last_d  = g_idx;
          grant_d = '0;
          timer_d = '0;
          state_d = ARB_IDLE;
        end else if (stb_g && !s_wb_ack_i) begin
          if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            timer_d = '0;
            state_d = ARB_TOACK;
            if (tcount_q != 8'hFF) tcount_d = tcount_q + 8'd1;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end else begin
          timer_d = '0;
        end
      end
      ARB_TOACK: begin
        timer_d = '0;
        if (cyc_g) begin
          state_d = ARB_BUSY;
        end else begin
          last_d  = g_idx;
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        timer_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(NUM_MASTERS - 1);
      timer_q  <= '0;
      tcount_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      tcount_q <= tcount_d;
    end
  end

  // A forced completion acks the master with a dummy read value while the slave side is idle.
  always_comb begin
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    s_wb_we_o  = 1'b0;
    s_wb_adr_o = '0;
    s_wb_dat_o = '0;
    m_wb_ack_o = '0;
    m_wb_dat_o = '0;
    if (state_q == ARB_BUSY) begin
      s_wb_cyc_o = cyc_g;
      s_wb_stb_o = stb_g;
      s_wb_we_o  = we_g;
      s_wb_adr_o = adr_g;
      s_wb_dat_o = dat_g;
      m_wb_ack_o = grant_q & {NUM_MASTERS{s_wb_ack_i}};
      m_wb_dat_o = s_wb_dat_i;
    end else if (state_q == ARB_TOACK) begin
      m_wb_ack_o = grant_q;
      m_wb_dat_o = TIMEOUT_READ_VALUE;
    end
  end

  assign grant         = grant_q;
  assign timeout_count = tcount_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================
// tb_wb_arbiter : directed self-checking bench for wb_arbiter
// Rev 1.0
// ============================================================
`default_nettype none

module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc, stb, we;
  logic [31:0] adr = {16'h0304, 16'h0102};
  logic [15:0] wdat = {8'h22, 8'h11};
  logic [7:0]  m_dat;
  logic [1:0]  m_ack;
  logic        s_cyc, s_stb, s_we;
  logic [15:0] s_adr;
  logic [7:0]  s_wdat;
  logic [7:0]  s_dat;
  logic        s_ack;
  logic [1:0]  grant;
  logic [7:0]  tcount;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_MASTERS (2),
    .ADDR_WIDTH  (16),
    .TIMEOUT     (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m_wb_cyc_i    (cyc),
    .m_wb_stb_i    (stb),
    .m_wb_we_i     (we),
    .m_wb_adr_i    (adr),
    .m_wb_dat_i    (wdat),
    .m_wb_dat_o    (m_dat),
    .m_wb_ack_o    (m_ack),
    .s_wb_cyc_o    (s_cyc),
    .s_wb_stb_o    (s_stb),
    .s_wb_we_o     (s_we),
    .s_wb_adr_o    (s_adr),
    .s_wb_dat_o    (s_wdat),
    .s_wb_dat_i    (s_dat),
    .s_wb_ack_i    (s_ack),
    .grant         (grant),
    .timeout_count (tcount)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic        s_ack;
    logic [7:0]  s_dat;
    logic [1:0]  e_grant;
    logic        e_scyc;
    logic        e_sstb;
    logic [15:0] e_adr;
    logic [1:0]  e_ack;
    logic [7:0]  e_mdat;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] s,
                              input logic a, input logic [7:0] d, input logic [1:0] eg,
                              input logic ec, input logic es, input logic [15:0] ea,
                              input logic [1:0] ek, input logic [7:0] em);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.s_ack = a; v.s_dat = d;
    v.e_grant = eg; v.e_scyc = ec; v.e_sstb = es; v.e_adr = ea; v.e_ack = ek; v.e_mdat = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    logic [1:0] exp_g;
    int n;

    rst = 1'b1; cyc = '0; stb = '0; we = '0; s_ack = 1'b0; s_dat = '0;
    repeat (2) @(posedge clk);
    #1;

    //            rst cyc    stb    ack  sdat   grant  sc  ss  adr       ack    mdat
    tbl[0]  = mk(0, 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 0, 16'h0000, 2'b00, 8'h00);
    tbl[1]  = mk(0, 2'b01, 2'b01, 0, 8'h00, 2'b00, 0, 0, 16'h0000, 2'b00, 8'h00);
    tbl[2]  = mk(0, 2'b01, 2'b01, 0, 8'h00, 2'b01, 1, 1, 16'h0102, 2'b00, 8'h00);
    tbl[3]  = mk(0, 2'b01, 2'b01, 0, 8'h00, 2'b01, 1, 1, 16'h0102, 2'b00, 8'h00);
    tbl[4]  = mk(0, 2'b01, 2'b01, 1, 8'h5A, 2'b01, 1, 1, 16'h0102, 2'b01, 8'h5A);
    tbl[5]  = mk(0, 2'b00, 2'b00, 0, 8'h00, 2'b01, 0, 0, 16'h0102, 2'b00, 8'h00);
    tbl[6]  = mk(1, 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 0, 16'h0000, 2'b00, 8'h00);
    tbl[7]  = mk(0, 2'b11, 2'b11, 0, 8'h00, 2'b00, 0, 0, 16'h0000, 2'b00, 8'h00);
    tbl[8]  = mk(0, 2'b11, 2'b11, 1, 8'h33, 2'b01, 1, 1, 16'h0102, 2'b01, 8'h33);
    tbl[9]  = mk(0, 2'b10, 2'b10, 0, 8'h00, 2'b01, 0, 0, 16'h0102, 2'b00, 8'h00);
    tbl[10] = mk(0, 2'b10, 2'b10, 0, 8'h00, 2'b00, 0, 0, 16'h0000, 2'b00, 8'h00);
    tbl[11] = mk(0, 2'b10, 2'b10, 1, 8'h44, 2'b10, 1, 1, 16'h0304, 2'b10, 8'h44);
    tbl[12] = mk(0, 2'b00, 2'b00, 0, 8'h00, 2'b10, 0, 0, 16'h0304, 2'b00, 8'h00);
    tbl[13] = mk(0, 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 0, 16'h0000, 2'b00, 8'h00);

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; cyc = tbl[i].cyc; stb = tbl[i].stb;
      s_ack = tbl[i].s_ack; s_dat = tbl[i].s_dat;
      @(negedge clk);
      chk($sformatf("r%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
      chk($sformatf("r%0d_scyc", i), 32'(s_cyc), 32'(tbl[i].e_scyc));
      chk($sformatf("r%0d_sstb", i), 32'(s_stb), 32'(tbl[i].e_sstb));
      chk($sformatf("r%0d_sadr", i), 32'(s_adr), 32'(tbl[i].e_adr));
      chk($sformatf("r%0d_mack", i), 32'(m_ack), 32'(tbl[i].e_ack));
      chk($sformatf("r%0d_mdat", i), 32'(m_dat), 32'(tbl[i].e_mdat));
      chk($sformatf("r%0d_tcount", i), 32'(tcount), 32'd0);
      @(posedge clk);
      #1;
    end

    // Fairness: both masters keep requesting; tenures must alternate.
    rst = 1'b0; s_ack = 1'b0; s_dat = '0;
    cyc = 2'b11; stb = 2'b11;
    exp_g = 2'b01;
    for (int t = 0; t < 12; t++) begin
      n = 0;
      @(negedge clk);
      while (grant == 2'b00 && n < 6) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("fair%0d_grant", t), 32'(grant), 32'(exp_g));
      s_ack = 1'b1;
      #1;
      chk($sformatf("fair%0d_ack", t), 32'(m_ack), 32'(exp_g));
      @(posedge clk);
      #1;
      s_ack = 1'b0;
      cyc = cyc & ~exp_g;
      stb = stb & ~exp_g;
      @(posedge clk);
      #1;
      cyc = 2'b11; stb = 2'b11;
      exp_g = {exp_g[0], exp_g[1]};
    end
    cyc = '0; stb = '0;
    repeat (3) @(posedge clk);

    // Watchdog: m1 write never acked.
    @(negedge clk);
    cyc = 2'b10; stb = 2'b10; we = 2'b10;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d_sstb", k), 32'(s_stb), 32'd1);
      chk($sformatf("to_wait%0d_mack", k), 32'(m_ack), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("to_scyc", 32'(s_cyc), 32'd0);
    chk("to_sstb", 32'(s_stb), 32'd0);
    chk("to_mack", 32'(m_ack), 32'b10);
    chk("to_mdat", 32'(m_dat), 32'hFF);
    chk("to_tcount", 32'(tcount), 32'd1);
    cyc = '0; stb = '0; we = '0;
    @(posedge clk);
    @(negedge clk);
    chk("to_release_grant", 32'(grant), 32'd0);
    chk("to_release_mack", 32'(m_ack), 32'd0);

    // Ack on the last allowed cycle wins over the watchdog.
    cyc = 2'b01; stb = 2'b01;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("edge_wait%0d_mack", k), 32'(m_ack), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    s_ack = 1'b1; s_dat = 8'hC3;
    #1;
    chk("edge_mack", 32'(m_ack), 32'b01);
    chk("edge_mdat", 32'(m_dat), 32'hC3);
    @(posedge clk);
    #1;
    s_ack = 1'b0; s_dat = '0; cyc = '0; stb = '0;
    @(negedge clk);
    chk("edge_after_mack", 32'(m_ack), 32'd0);
    chk("edge_after_mdat", 32'(m_dat), 32'd0);
    chk("edge_tcount", 32'(tcount), 32'd1);
    @(posedge clk);

    // Reset in the middle of a pending m1 transfer.
    @(negedge clk);
    cyc = 2'b10; stb = 2'b10; we = 2'b10;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pre_grant", 32'(grant), 32'b10);
    rst = 1'b1; cyc = 2'b11; stb = 2'b11;
    @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_scyc", 32'(s_cyc), 32'd0);
    chk("rst_mack", 32'(m_ack), 32'd0);
    chk("rst_tcount", 32'(tcount), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_after_grant", 32'(grant), 32'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
